phtime_multi: RTL and testbench

- Parametrised multi-lane phase-time generator for the DDS/NCO path.
- Each clock emits NLANE phases for consecutive samples: phase = f*S + offset mod 2^PHWIDTH, where S is the absolute sample index since reset.
- Supports runtime frequency/offset update in two modes:
  - coherent: phase referenced to absolute time.
  - continuous: phase-continuous hop.
- Feeds the per-lane sin/cos lookup ahead of the RFDC DAC/ADC mixers.

---
 rtl/phtime_multi.sv | 122 ++++++++++++
 tb/tb_phtime_multi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/phtime_multi.sv
// phtime_multi: multi-lane phase-time generator, NLANE phases per clock with coherent/continuous retune.
// Optional PHTIME_ERRCHK_EN adds a sticky err output driven by an accumulator-based reference checker.
module phtime_multi #(
    parameter int PHWIDTH   = 27,
    parameter int NLANE     = 4,
    parameter int TCNTWIDTH = 18,
    parameter int LATENCY   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PHWIDTH-1:0]       freq,
    input  logic [PHWIDTH-1:0]       phoff,
    input  logic                     mode,
    input  logic                     freq_wr,
    output logic [NLANE*PHWIDTH-1:0] phasetime,
    output logic                     valid
`ifdef PHTIME_ERRCHK_EN
    ,
    output logic                     err
`endif
);
    localparam logic [PHWIDTH-1:0] NL    = PHWIDTH'(NLANE);
    localparam logic [PHWIDTH-1:0] ONE   = PHWIDTH'(1);
    localparam logic [PHWIDTH-1:0] TMASK = PHWIDTH'((64'd1 << TCNTWIDTH) - 64'd1);
    localparam int                 ND    = LATENCY - 4;
    logic [PHWIDTH-1:0] r_freq, r_off, r_cnt, r_cw, r_base, r_acc;
    logic               r_mode;
    logic [PHWIDTH-1:0] w_freq, w_off, w_cw, w_base, w_lane0, w_t;
    logic               w_mode;
    logic [PHWIDTH-1:0] r1_f, r1_ts, r1_b, r1_off;
    logic [PHWIDTH-1:0] r2_f, r2_plo, r2_phi, r2_bo;
    logic [PHWIDTH-1:0] r3_f, r3_p0;
    logic [NLANE*PHWIDTH-1:0] r_dly [0:ND];
    logic [LATENCY-1:0] r_vld;
    // A strobe takes effect in its own cycle, so the pipeline sees the incoming settings directly.
    always_comb begin
        w_freq  = freq_wr ? freq : r_freq;
        w_off   = freq_wr ? phoff : r_off;
        w_mode  = freq_wr ? mode : r_mode;
        w_cw    = freq_wr ? r_cnt : r_cw;
        w_base  = freq_wr ? r_acc : r_base;
        w_t     = w_mode ? r_cnt - w_cw : r_cnt;
        w_lane0 = (freq_wr && !mode) ? freq * NL * r_cnt : r_acc;
    end
    // r_acc holds lane-0 phase (no offset) of the current cycle; it is the base for a continuous hop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq <= freq;
            r_off  <= phoff;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_cw   <= '0;
            r_base <= '0;
            r_acc  <= '0;
        end else begin
            r_freq <= w_freq;
            r_off  <= w_off;
            r_mode <= w_mode;
            r_cnt  <= r_cnt + ONE;
            r_cw   <= w_cw;
            r_base <= w_base;
            r_acc  <= w_lane0 + NL * w_freq;
        end
    end
    // Time operand split at TCNTWIDTH; the two partial products recombine exactly modulo 2^PHWIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_f   <= '0;
            r1_ts  <= '0;
            r1_b   <= '0;
            r1_off <= '0;
            r2_f   <= '0;
            r2_plo <= '0;
            r2_phi <= '0;
            r2_bo  <= '0;
            r3_f   <= '0;
            r3_p0  <= '0;
            for (int i = 0; i <= ND; i++) r_dly[i] <= '0;
            r_vld  <= '0;
        end else begin
            r1_f   <= w_freq;
            r1_ts  <= NL * w_t;
            r1_b   <= w_mode ? w_base : '0;
            r1_off <= w_off;
            r2_f   <= r1_f;
            r2_plo <= r1_f * (r1_ts & TMASK);
            r2_phi <= r1_f * (r1_ts & ~TMASK);
            r2_bo  <= r1_b + r1_off;
            r3_f   <= r2_f;
            r3_p0  <= r2_plo + r2_phi + r2_bo;
            for (int k = 0; k < NLANE; k++) r_dly[0][k*PHWIDTH +: PHWIDTH] <= r3_p0 + PHWIDTH'(k) * r3_f;
            for (int i = 1; i <= ND; i++) r_dly[i] <= r_dly[i-1];
            r_vld  <= {r_vld[LATENCY-2:0], 1'b1};
        end
    end
    assign phasetime = r_dly[ND];
    assign valid     = r_vld[LATENCY-1];
`ifdef PHTIME_ERRCHK_EN
    logic [PHWIDTH-1:0] r_ref [0:LATENCY-1];
    logic [PHWIDTH-1:0] r_rf  [0:LATENCY-1];
    logic               r_err, w_bad;
    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < NLANE; k++)
            if (phasetime[k*PHWIDTH +: PHWIDTH] != r_ref[LATENCY-1] + PHWIDTH'(k) * r_rf[LATENCY-1]) w_bad = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_ref[i] <= '0;
            for (int i = 0; i < LATENCY; i++) r_rf[i] <= '0;
            r_err <= 1'b0;
        end else begin
            r_ref[0] <= w_lane0 + w_off;
            r_rf[0]  <= w_freq;
            for (int i = 1; i < LATENCY; i++) r_ref[i] <= r_ref[i-1];
            for (int i = 1; i < LATENCY; i++) r_rf[i] <= r_rf[i-1];
            r_err    <= r_err | (valid & w_bad);
        end
    end
    assign err = r_err;
`endif
endmodule

// File: tb/tb_phtime_multi.sv
// tb_phtime_multi: randomized self-checking bench for phtime_multi against a sample-index phase model.
// TCNTWIDTH is shrunk so the time-slice boundary is crossed in a short run; results must not depend on it.
module tb_phtime_multi;
    localparam int     W   = 27;
    localparam int     NL  = 4;
    localparam int     L   = 5;
    localparam int     TCW = 12;
    localparam longint M   = (longint'(1) << W) - 1;
    logic clk = 1'b0, reset = 1'b1, mode = 1'b0, freq_wr = 1'b0;
    logic [W-1:0] freq = '0, phoff = '0;
    logic [NL*W-1:0] phasetime;
    logic valid;
`ifdef PHTIME_ERRCHK_EN
    logic err;
`endif
    int checks = 0, errors = 0;
    longint mf, mo, mb, mcw;
    bit mm;
    int n = 0;
    logic [NL*W-1:0] exp_q [$];
    logic [NL*W-1:0] obs_w, exp_w;
    logic obs_v, exp_v;

    always #5 clk = ~clk;

    phtime_multi #(.PHWIDTH(W), .NLANE(NL), .TCNTWIDTH(TCW), .LATENCY(L)) dut (
        .clk(clk), .reset(reset), .freq(freq), .phoff(phoff), .mode(mode), .freq_wr(freq_wr),
        .phasetime(phasetime), .valid(valid)
`ifdef PHTIME_ERRCHK_EN
        , .err(err)
`endif
    );

    // Phase of absolute sample s under the current model settings, before the offset.
    function automatic longint raw_phase(longint s);
        return mm ? mb + mf * (s - NL * mcw) : mf * s;
    endfunction

    function automatic logic [NL*W-1:0] word_at(longint c);
        logic [NL*W-1:0] r;
        for (int k = 0; k < NL; k++) r[k*W +: W] = W'((raw_phase(NL * c + k) + mo) & M);
        return r;
    endfunction

    function automatic logic [NL*W-1:0] pack4(longint a, longint b, longint c, longint d);
        return {W'(d & M), W'(c & M), W'(b & M), W'(a & M)};
    endfunction

    task automatic tick(input bit rst, input bit wr, input logic [W-1:0] f, input logic [W-1:0] off, input bit md);
        reset = rst; freq_wr = wr; freq = f; phoff = off; mode = md;
        if (rst) begin
            mf = f; mo = off; mm = 0; mb = 0; mcw = 0; n = 0;
            exp_q.delete();
        end else begin
            if (wr) begin
                mb = raw_phase(NL * n) & M;
                mcw = n; mf = f; mo = off; mm = md;
            end
            exp_q.push_back(word_at(n));
            n++;
        end
        @(posedge clk); #1;
        obs_w = phasetime; obs_v = valid;
        exp_v = !rst && n >= L;
        exp_w = exp_v ? exp_q[n-L] : '0;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 5, 5, 1);
        checks++;
        if (obs_v !== 1'b0 || obs_w !== '0) begin
            errors++;
            $display("FAIL reset: got valid=%b word=%h exp valid=0 word=0", obs_v, obs_w);
        end
    endtask

    task automatic test_basic();
        tick(1, 0, 1000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, W'($urandom), W'($urandom), 1'($urandom));
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL basic n=%0d: got valid=%b word=%h exp valid=%b word=%h", n, obs_v, obs_w, exp_v, exp_w);
            end
            if (n == L || n == L + 1) begin
                checks++;
                if (obs_w !== pack4((n - L) * 4000, (n - L) * 4000 + 1000, (n - L) * 4000 + 2000, (n - L) * 4000 + 3000)) begin
                    errors++;
                    $display("FAIL basic_const n=%0d: got word=%h", n, obs_w);
                end
            end
        end
    endtask

    task automatic test_wrap();
        longint tf [4] = '{1 << 25, 1 << 25, 0, 1 << 26};
        longint to [4] = '{0, 5, 123, 0};
        tick(1, 0, 0, 0, 0);
        for (int e = 0; e < 4; e++) begin
            int cwr = n;
            tick(0, 1, W'(tf[e]), W'(to[e]), 0);
            for (int i = 0; i < 10; i++) begin
                tick(0, 0, W'($urandom), W'($urandom), 0);
                checks++;
                if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                    errors++;
                    $display("FAIL wrap e=%0d: got valid=%b word=%h exp valid=%b word=%h", e, obs_v, obs_w, exp_v, exp_w);
                end
                if (exp_v && n - L >= cwr) begin
                    checks++;
                    if (obs_w !== pack4(to[e], tf[e] + to[e], 2 * tf[e] + to[e], 3 * tf[e] + to[e])) begin
                        errors++;
                        $display("FAIL wrap_const e=%0d: got word=%h", e, obs_w);
                    end
                end
            end
        end
    endtask

    task automatic test_long();
        tick(1, 0, 3, 0, 0);
        for (int i = 0; i < 1100; i++) begin
            tick(0, 0, W'($urandom), 0, 0);
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL long n=%0d: got valid=%b word=%h exp valid=%b word=%h", n, obs_v, obs_w, exp_v, exp_w);
            end
        end
`ifdef PHTIME_ERRCHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL long_err: got err=%b exp 0", err);
        end
`endif
    endtask

    task automatic test_hop(input bit md);
        tick(1, 0, 1000, 0, 0);
        for (int c = 0; c < 20; c++) begin
            tick(0, c == 10, (c == 10) ? W'(500) : W'($urandom), 0, md);
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL hop md=%0d n=%0d: got valid=%b word=%h exp valid=%b word=%h", md, n, obs_v, obs_w, exp_v, exp_w);
            end
            if (exp_v && (n - L == 9 || n - L == 10)) begin
                logic [NL*W-1:0] want;
                want = (n - L == 9) ? pack4(36000, 37000, 38000, 39000) :
                       md ? pack4(40000, 40500, 41000, 41500) : pack4(20000, 20500, 21000, 21500);
                checks++;
                if (obs_w !== want) begin
                    errors++;
                    $display("FAIL hop_const md=%0d c=%0d: got word=%h exp word=%h", md, n - L, obs_w, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 1000, 0, 0);
        for (int c = 0; c < 100; c++) begin
            tick(0, 0, 1000, 0, 0);
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL reset_mid run n=%0d: got valid=%b word=%h exp valid=%b word=%h", n, obs_v, obs_w, exp_v, exp_w);
            end
        end
        tick(1, 1, 1000, 0, 1);
        checks++;
        if (obs_v !== 1'b0 || obs_w !== '0) begin
            errors++;
            $display("FAIL reset_mid edge: got valid=%b word=%h exp valid=0 word=0", obs_v, obs_w);
        end
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, W'($urandom), 0, 0);
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL reset_mid restart n=%0d: got valid=%b word=%h exp valid=%b word=%h", n, obs_v, obs_w, exp_v, exp_w);
            end
            if (n == L) begin
                checks++;
                if (obs_w !== pack4(0, 1000, 2000, 3000)) begin
                    errors++;
                    $display("FAIL reset_mid first: got word=%h", obs_w);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1, 0, W'($urandom), W'($urandom), 0);
        for (int c = 0; c < 400; c++) begin
            tick(0, $urandom_range(0, 3) == 0, W'($urandom), W'($urandom), 1'($urandom));
            checks++;
            if (obs_v !== exp_v || (exp_v && obs_w !== exp_w)) begin
                errors++;
                $display("FAIL back_to_back n=%0d: got valid=%b word=%h exp valid=%b word=%h", n, obs_v, obs_w, exp_v, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_long();
        test_hop(1'b1);
        test_hop(1'b0);
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
